// File: rtl/vend_fsm_param.sv
// Parametrised vending controller: accumulates nickel-unit credit, pulses Dispense at PRICE_N,
// then pays change greedily one coin per cycle. Optional refund on Cancel: define VEND_CANCEL_EN.
module vend_fsm_param #(
  parameter int unsigned PRICE_N = 5,
  parameter int unsigned CRED_W  = 6,
  parameter int unsigned CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Nickel,
  input  logic              Dime,
  input  logic              Quarter,
  input  logic              Cancel,
  output logic              Dispense,
  output logic              ReturnNickel,
  output logic              ReturnDime,
  output logic              ReturnQuarter,
  output logic              CoinReject,
  output logic              Busy,
  output logic [CRED_W-1:0] Credit,
  output logic [CNT_W-1:0]  VendCount
);

  typedef enum logic {IDLE, CHANGE} state_t;

  localparam logic [CRED_W-1:0] PRICE  = CRED_W'(PRICE_N);
  localparam logic [CRED_W-1:0] VAL_N  = CRED_W'(1);
  localparam logic [CRED_W-1:0] VAL_D  = CRED_W'(2);
  localparam logic [CRED_W-1:0] VAL_Q  = CRED_W'(5);

  state_t state_q, state_d;

  logic [1:0]        coin_cnt;
  logic              any_coin;
  logic              cancel_c;
  logic              refund_c;
  logic              accept_c;
  logic [CRED_W-1:0] coin_val;
  logic [CRED_W-1:0] sum;
  logic              reach_c;
  logic [CRED_W-1:0] pay_val;

  logic              dispense_d, ret_n_d, ret_d_d, ret_q_d, reject_d, busy_d;
  logic [CRED_W-1:0] credit_d;
  logic [CNT_W-1:0]  vend_count_d;

  // Refund only exists when the macro is defined; otherwise Cancel is a dead input.
`ifdef VEND_CANCEL_EN
  assign cancel_c = Cancel;
`else
  logic unused_cancel;
  assign unused_cancel = Cancel;
  assign cancel_c      = 1'b0;
`endif

  assign coin_cnt = {1'b0, Nickel} + {1'b0, Dime} + {1'b0, Quarter};
  assign any_coin = Nickel | Dime | Quarter;
  assign refund_c = cancel_c && (Credit != '0);
  assign accept_c = (coin_cnt == 2'd1) && !cancel_c;
  assign coin_val = Quarter ? VAL_Q : (Dime ? VAL_D : VAL_N);
  assign sum      = Credit + coin_val;
  assign reach_c  = (sum >= PRICE);
  assign pay_val  = (Credit >= VAL_Q) ? VAL_Q : ((Credit >= VAL_D) ? VAL_D : VAL_N);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (refund_c)                                state_d = CHANGE;
        else if (accept_c && reach_c && sum != PRICE) state_d = CHANGE;
      end
      CHANGE: begin
        if (Credit == pay_val) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Next output values
  always_comb begin
    dispense_d   = 1'b0;
    ret_n_d      = 1'b0;
    ret_d_d      = 1'b0;
    ret_q_d      = 1'b0;
    reject_d     = 1'b0;
    busy_d       = 1'b0;
    credit_d     = Credit;
    vend_count_d = VendCount;
    case (state_q)
      IDLE: begin
        // A coin arriving alongside Cancel, or several coins at once, is never credited.
        reject_d = any_coin && ((coin_cnt > 2'd1) || cancel_c);
        if (accept_c) begin
          if (reach_c) begin
            dispense_d   = 1'b1;
            vend_count_d = VendCount + CNT_W'(1);
            credit_d     = sum - PRICE;
          end else begin
            credit_d = sum;
          end
        end
      end
      CHANGE: begin
        reject_d = any_coin;
        busy_d   = 1'b1;
        credit_d = Credit - pay_val;
        ret_q_d  = (pay_val == VAL_Q);
        ret_d_d  = (pay_val == VAL_D);
        ret_n_d  = (pay_val == VAL_N);
      end
      default: ;
    endcase
  end

  // Output register
  always_ff @(posedge clk) begin
    if (rst) begin
      Dispense      <= 1'b0;
      ReturnNickel  <= 1'b0;
      ReturnDime    <= 1'b0;
      ReturnQuarter <= 1'b0;
      CoinReject    <= 1'b0;
      Busy          <= 1'b0;
      Credit        <= '0;
      VendCount     <= '0;
    end else begin
      Dispense      <= dispense_d;
      ReturnNickel  <= ret_n_d;
      ReturnDime    <= ret_d_d;
      ReturnQuarter <= ret_q_d;
      CoinReject    <= reject_d;
      Busy          <= busy_d;
      Credit        <= credit_d;
      VendCount     <= vend_count_d;
    end
  end

endmodule

// File: tb/tb_vend_fsm_param.sv
// Scoreboard bench for vend_fsm_param (PRICE_N=5, CRED_W=6, CNT_W=2).
module tb_vend_fsm_param;

  localparam int unsigned PRICE_N = 5;
  localparam int unsigned CRED_W  = 6;
  localparam int unsigned CNT_W   = 2;

  logic clk = 1'b0;
  logic rst, Nickel, Dime, Quarter, Cancel;
  logic Dispense, ReturnNickel, ReturnDime, ReturnQuarter, CoinReject, Busy;
  logic [CRED_W-1:0] Credit;
  logic [CNT_W-1:0]  VendCount;

  vend_fsm_param #(.PRICE_N(PRICE_N), .CRED_W(CRED_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .Nickel(Nickel), .Dime(Dime), .Quarter(Quarter), .Cancel(Cancel),
    .Dispense(Dispense), .ReturnNickel(ReturnNickel), .ReturnDime(ReturnDime),
    .ReturnQuarter(ReturnQuarter), .CoinReject(CoinReject), .Busy(Busy),
    .Credit(Credit), .VendCount(VendCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit disp, rn, rd, rq, rej, busy;
    int credit, count;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int m_credit = 0;
  int m_count  = 0;
  bit m_change = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model_step(input bit r, input bit n, input bit d, input bit q, input bit c);
    exp_t e = '{default: 0};
    int ncoin = int'(n) + int'(d) + int'(q);
    int val   = q ? 5 : (d ? 2 : 1);
    int total;
    if (r) begin
      m_credit = 0; m_count = 0; m_change = 0;
    end else if (m_change) begin
      e.rej  = (ncoin != 0);
      e.busy = 1;
      if (m_credit >= 5)      begin e.rq = 1; m_credit -= 5; end
      else if (m_credit >= 2) begin e.rd = 1; m_credit -= 2; end
      else                    begin e.rn = 1; m_credit -= 1; end
      if (m_credit == 0) m_change = 0;
    end else begin
`ifdef VEND_CANCEL_EN
      if (c) begin
        e.rej = (ncoin != 0);
        if (m_credit > 0) m_change = 1;
      end else
`endif
      if (ncoin > 1) e.rej = 1;
      else if (ncoin == 1) begin
        total = m_credit + val;
        if (total >= int'(PRICE_N)) begin
          e.disp   = 1;
          m_count  = (m_count + 1) % (1 << CNT_W);
          m_credit = total - int'(PRICE_N);
          m_change = (m_credit != 0);
        end else begin
          m_credit = total;
        end
      end
    end
    e.credit = m_credit;
    e.count  = m_count;
    return e;
  endfunction

  // Drive one cycle of stimulus, push the expectation, then pop and compare after the edge.
  task automatic tick(input bit r, input bit n, input bit d, input bit q, input bit c);
    exp_t e;
    rst = r; Nickel = n; Dime = d; Quarter = q; Cancel = c;
    sb.push_back(model_step(r, n, d, q, c));
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_eq("Dispense",      int'(Dispense),      int'(e.disp));
    check_eq("ReturnNickel",  int'(ReturnNickel),  int'(e.rn));
    check_eq("ReturnDime",    int'(ReturnDime),    int'(e.rd));
    check_eq("ReturnQuarter", int'(ReturnQuarter), int'(e.rq));
    check_eq("CoinReject",    int'(CoinReject),    int'(e.rej));
    check_eq("Busy",          int'(Busy),          int'(e.busy));
    check_eq("Credit",        int'(Credit),        e.credit);
    check_eq("VendCount",     int'(VendCount),     e.count);
    rst = 0; Nickel = 0; Dime = 0; Quarter = 0; Cancel = 0;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) tick(0, 0, 0, 0, 0);
  endtask

  initial begin
    int wrap_exp [4];
    bit rn, rd, rq, rc;
    wrap_exp[0] = 1; wrap_exp[1] = 2; wrap_exp[2] = 3; wrap_exp[3] = 0;
    rst = 1; Nickel = 0; Dime = 0; Quarter = 0; Cancel = 0;
    @(negedge clk);

    tick(1, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    check_eq("reset_credit", int'(Credit), 0);

    // Dime, Dime, Quarter: credit 2, 4, vend with remainder 4 paid as two dimes
    tick(0, 0, 1, 0, 0); check_eq("dd_q_credit1", int'(Credit), 2);
    tick(0, 0, 1, 0, 0); check_eq("dd_q_credit2", int'(Credit), 4);
    tick(0, 0, 0, 1, 0); check_eq("dd_q_disp", int'(Dispense), 1);
    tick(0, 0, 0, 0, 0); check_eq("dd_q_ret1", int'(ReturnDime & Busy), 1);
    tick(0, 0, 0, 0, 0); check_eq("dd_q_ret2", int'(ReturnDime & Busy), 1);
    idle(1);             check_eq("dd_q_count", int'(VendCount), 1);

    // Five nickels: exact price, no change
    for (int i = 0; i < 5; i++) tick(0, 1, 0, 0, 0);
    idle(2);

    // Coin during payout is rejected; coin in the cycle Busy falls is accepted
    tick(0, 0, 1, 0, 0);
    tick(0, 0, 1, 0, 0);
    tick(0, 0, 0, 1, 0);
    tick(0, 1, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 0); check_eq("busy_fall_accept", int'(Credit), 1);
    for (int i = 0; i < 4; i++) tick(0, 1, 0, 0, 0);
    idle(1);

    // Two coins at once are rejected; reset mid-payout clears everything
    tick(0, 0, 1, 0, 0);
    tick(0, 1, 1, 0, 0); check_eq("dual_coin_credit", int'(Credit), 2);
    tick(0, 0, 1, 0, 0);
    tick(0, 0, 0, 1, 0);
    tick(0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0); check_eq("rst_mid_change", int'(Busy | ReturnDime | Credit != 0), 0);
    idle(1);

    // Dime, Nickel, Cancel
    tick(0, 0, 1, 0, 0);
    tick(0, 1, 0, 0, 0);
    tick(0, 0, 0, 0, 1);
    idle(1);
`ifdef VEND_CANCEL_EN
    check_eq("cancel_refund", int'(ReturnDime), 1);
    idle(3);
`else
    check_eq("cancel_ignored", int'(Credit), 3);
    tick(0, 1, 0, 0, 0);
    tick(0, 1, 0, 0, 0);
    idle(1);
`endif

    // Counter wrap on a 2-bit VendCount
    tick(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      tick(0, 0, 0, 1, 0);
      check_eq("wrap_count", int'(VendCount), wrap_exp[i]);
    end

    // Random traffic including multi-coin and Cancel pulses
    for (int i = 0; i < 400; i++) begin
      rn = ($urandom_range(0, 3) == 0);
      rd = ($urandom_range(0, 3) == 0);
      rq = ($urandom_range(0, 4) == 0);
      rc = ($urandom_range(0, 9) == 0);
      tick(($urandom_range(0, 99) == 0), rn, rd, rq, rc);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
